interrupt_controller: RTL and testbench

//  Peripheral-side end of the RAT CPU interrupt interface. Latches rising edges on up to 8

---
 rtl/interrupt_controller.sv | 119 +++++++++++
 tb/tb_interrupt_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt controller for the RAT CPU. It latches rising edges on the request lines into
// PEND, gates them with MASK, and runs an INTR / ack / EOI handshake over the port bus.
module interrupt_controller #(
   parameter int          NUM_SRC     = 8,
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  MASK_PORT   = 8'hF0,
   parameter logic [7:0]  PEND_PORT   = 8'hF1,
   parameter logic [7:0]  ID_PORT     = 8'hF2,
   parameter logic [7:0]  EOI_PORT    = 8'hF3
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [NUM_SRC-1:0] IRQ_IN,
   input  logic [7:0]         PORT_ID,
   input  logic [7:0]         OUT_PORT,
   input  logic               IO_STRB,
   input  logic               INTR_ACK,
   output logic               INTR,
   output logic [7:0]         IN_PORT_DATA
);
   typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} state_t;

   state_t                              state_q, state_d;
   logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
   logic [NUM_SRC-1:0]                  prev_q, rise;
   logic [NUM_SRC-1:0]                  pend_q, pend_d, mask_q, mask_d, active, clr;
   logic [2:0]                          id_q, id_d, winner;
   logic                                valid_q, valid_d, intr_q, intr_d;
   logic                                req, wr_mask, wr_pend, wr_eoi, ack_take;

   // prev_q resets low, so a line already high at reset release counts as one edge
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= IRQ_IN;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign active   = pend_q & mask_q;
   assign req      = |active;
   assign wr_mask  = IO_STRB && (PORT_ID == MASK_PORT);
   assign wr_pend  = IO_STRB && (PORT_ID == PEND_PORT);
   assign wr_eoi   = IO_STRB && (PORT_ID == EOI_PORT);
   assign ack_take = (state_q == ST_ASSERT) && INTR_ACK && req;

   always_comb begin
      winner = '0;
      for (int i = NUM_SRC-1; i >= 0; i--)
         if (active[i]) winner = 3'(i);
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE:    if (req) state_d = ST_ASSERT;
         ST_ASSERT: begin
            if (ack_take) begin
               state_d = ST_SERVICE;
               id_d    = winner;
               valid_d = 1'b1;
            end else if (!req) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (wr_eoi) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end
         default:    state_d = ST_IDLE;
      endcase
      intr_d = (state_d == ST_ASSERT);
   end

   // A fresh edge overrides any clear (W1C or ack) landing in the same cycle
   always_comb begin
      clr = wr_pend ? OUT_PORT[NUM_SRC-1:0] : '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (ack_take && (winner == 3'(i))) clr[i] = 1'b1;
      pend_d = (pend_q & ~clr) | rise;
      mask_d = wr_mask ? OUT_PORT[NUM_SRC-1:0] : mask_q;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         mask_q  <= '0;
         id_q    <= '0;
         valid_q <= 1'b0;
         intr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         id_q    <= id_d;
         valid_q <= valid_d;
         intr_q  <= intr_d;
      end
   end

   assign INTR = intr_q;

   always_comb begin
      IN_PORT_DATA = 8'h00;
      if (PORT_ID == MASK_PORT)      IN_PORT_DATA[NUM_SRC-1:0] = mask_q;
      else if (PORT_ID == PEND_PORT) IN_PORT_DATA[NUM_SRC-1:0] = pend_q;
      else if (PORT_ID == ID_PORT)   IN_PORT_DATA = {valid_q, 4'b0000, id_q};
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios with fixed expectations, then a random
// run compared against a cycle-level reference model of the controller's rules.
module tb_interrupt_controller;
   localparam int S = 2;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic [7:0] IRQ_IN = '0;
   logic [7:0] PORT_ID = '0;
   logic [7:0] OUT_PORT = '0;
   logic       IO_STRB = 1'b0;
   logic       INTR_ACK = 1'b0;
   logic       INTR;
   logic [7:0] IN_PORT_DATA;

   int errors = 0;
   int checks = 0;

   interrupt_controller #(.NUM_SRC(8), .SYNC_STAGES(S)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .IRQ_IN(IRQ_IN), .PORT_ID(PORT_ID),
      .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .INTR_ACK(INTR_ACK),
      .INTR(INTR), .IN_PORT_DATA(IN_PORT_DATA)
   );

   always #5 CLK = ~CLK;

   // Reference model: intr=1 means "requesting", valid=1 means "in service"
   typedef struct packed {
      logic [7:0] pend;
      logic [7:0] mask;
      logic [2:0] id;
      logic       valid;
      logic       intr;
   } mstate_t;

   mstate_t    ms;
   logic [7:0] samp [0:4095];
   int         mcyc;

   // A request lands S edges after it is first sampled, if the sample before it was low
   function automatic logic [7:0] rise_at(int n);
      logic [7:0] a, b;
      a = (n >= S)     ? samp[(n-S) % 4096]   : 8'h00;
      b = (n >= S + 1) ? samp[(n-S-1) % 4096] : 8'h00;
      return a & ~b;
   endfunction

   function automatic mstate_t model_next(mstate_t s, logic [7:0] rise, logic strb,
                                          logic [7:0] pid, logic [7:0] dat, logic ack);
      mstate_t    n;
      logic [7:0] act;
      int         w;
      n   = s;
      act = s.pend & s.mask;
      w   = -1;
      for (int i = 7; i >= 0; i--) if (act[i]) w = i;
      if (strb && pid == 8'hF0) n.mask = dat;
      if (strb && pid == 8'hF1) n.pend = n.pend & ~dat;
      if (s.intr) begin
         if (ack && w >= 0) begin
            n.pend[w] = 1'b0;
            n.id      = 3'(w);
            n.valid   = 1'b1;
            n.intr    = 1'b0;
         end else if (w < 0) begin
            n.intr = 1'b0;
         end
      end else if (s.valid) begin
         if (strb && pid == 8'hF3) n.valid = 1'b0;
      end else begin
         n.intr = (w >= 0);
      end
      n.pend = n.pend | rise;
      return n;
   endfunction

   function automatic logic [7:0] model_read(mstate_t s, logic [7:0] pid);
      case (pid)
         8'hF0:   return s.mask;
         8'hF1:   return s.pend;
         8'hF2:   return {s.valid, 4'b0000, s.id};
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ms   <= '0;
         mcyc <= 0;
      end else begin
         samp[mcyc % 4096] <= IRQ_IN;
         ms   <= model_next(ms, rise_at(mcyc), IO_STRB, PORT_ID, OUT_PORT, INTR_ACK);
         mcyc <= mcyc + 1;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [7:0] port, input logic [7:0] dat);
      IO_STRB  = 1'b1;
      PORT_ID  = port;
      OUT_PORT = dat;
      tick();
      IO_STRB  = 1'b0;
   endtask

   task automatic test_reset();
      IRQ_IN[7] = 1'b1;
      repeat (2) tick();
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL rst_intr: got %b want 0", INTR); end
      for (int p = 0; p < 4; p++) begin
         PORT_ID = 8'hF0 + 8'(p);
         #1;
         checks++;
         if (IN_PORT_DATA !== 8'h00) begin
            errors++; $display("FAIL rst_read_%h: got %h want 00", PORT_ID, IN_PORT_DATA);
         end
      end
      @(negedge CLK) RESET_N = 1'b1;
      repeat (3) tick();
      PORT_ID = 8'hF1; #1;
      checks++; if (IN_PORT_DATA !== 8'h80) begin errors++; $display("FAIL rst_high_edge: got %h want 80", IN_PORT_DATA); end
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL rst_masked: got %b want 0", INTR); end
      IRQ_IN = '0;
      wr(8'hF1, 8'h80);
      PORT_ID = 8'h10; #1;
      checks++; if (IN_PORT_DATA !== 8'h00) begin errors++; $display("FAIL unmapped: got %h want 00", IN_PORT_DATA); end
   endtask

   task automatic test_edge_latency();
      wr(8'hF0, 8'h04);
      PORT_ID = 8'hF1;
      IRQ_IN[2] = 1'b1;
      tick(); tick();
      checks++; if (IN_PORT_DATA !== 8'h00) begin errors++; $display("FAIL lat_early: got %h want 00", IN_PORT_DATA); end
      tick();
      checks++; if (IN_PORT_DATA !== 8'h04) begin errors++; $display("FAIL lat_pend: got %h want 04", IN_PORT_DATA); end
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL lat_intr_early: got %b want 0", INTR); end
      tick();
      checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL lat_intr: got %b want 1", INTR); end
      IRQ_IN = '0;
      INTR_ACK = 1'b1; tick(); INTR_ACK = 1'b0;
      PORT_ID = 8'hF2; #1;
      checks++; if (IN_PORT_DATA !== 8'h82) begin errors++; $display("FAIL lat_id: got %h want 82", IN_PORT_DATA); end
      wr(8'hF3, 8'h00);
      PORT_ID = 8'hF2; #1;
      checks++; if (IN_PORT_DATA !== 8'h02) begin errors++; $display("FAIL lat_eoi: got %h want 02", IN_PORT_DATA); end
   endtask

   task automatic test_ack_eoi();
      wr(8'hF0, 8'hFF);
      IRQ_IN = 8'h0A;
      repeat (4) tick();
      PORT_ID = 8'hF1; #1;
      checks++; if (IN_PORT_DATA !== 8'h0A) begin errors++; $display("FAIL ack_pend0: got %h want 0a", IN_PORT_DATA); end
      checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL ack_intr0: got %b want 1", INTR); end
      INTR_ACK = 1'b1; tick(); INTR_ACK = 1'b0;
      checks++; if (IN_PORT_DATA !== 8'h08) begin errors++; $display("FAIL ack_pend: got %h want 08", IN_PORT_DATA); end
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL ack_intr: got %b want 0", INTR); end
      PORT_ID = 8'hF2; #1;
      checks++; if (IN_PORT_DATA !== 8'h81) begin errors++; $display("FAIL ack_id: got %h want 81", IN_PORT_DATA); end
      wr(8'hF3, 8'h5A);
      PORT_ID = 8'hF2; #1;
      checks++; if (IN_PORT_DATA !== 8'h01) begin errors++; $display("FAIL eoi_id: got %h want 01", IN_PORT_DATA); end
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL eoi_intr0: got %b want 0", INTR); end
      tick();
      checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL eoi_reassert: got %b want 1", INTR); end
      INTR_ACK = 1'b1; tick(); INTR_ACK = 1'b0;
      checks++; if (IN_PORT_DATA !== 8'h83) begin errors++; $display("FAIL ack_id3: got %h want 83", IN_PORT_DATA); end
      wr(8'hF3, 8'h00);
      IRQ_IN = '0;
   endtask

   task automatic test_masked();
      wr(8'hF0, 8'h00);
      IRQ_IN[5] = 1'b1;
      repeat (4) tick();
      PORT_ID = 8'hF1; #1;
      checks++; if (IN_PORT_DATA !== 8'h20) begin errors++; $display("FAIL msk_pend: got %h want 20", IN_PORT_DATA); end
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL msk_intr: got %b want 0", INTR); end
      wr(8'hF0, 8'h20);
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL msk_wr_intr: got %b want 0", INTR); end
      PORT_ID = 8'hF0; #1;
      checks++; if (IN_PORT_DATA !== 8'h20) begin errors++; $display("FAIL msk_read: got %h want 20", IN_PORT_DATA); end
      tick();
      checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL msk_unmask: got %b want 1", INTR); end
      IRQ_IN = '0;
   endtask

   task automatic test_w1c_cancel();
      wr(8'hF1, 8'hFF);
      PORT_ID = 8'hF1; #1;
      checks++; if (IN_PORT_DATA !== 8'h00) begin errors++; $display("FAIL w1c_pend: got %h want 00", IN_PORT_DATA); end
      tick();
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL w1c_intr: got %b want 0", INTR); end
      INTR_ACK = 1'b1; tick(); INTR_ACK = 1'b0;
      tick();
      PORT_ID = 8'hF2; #1;
      checks++; if (IN_PORT_DATA !== 8'h03) begin errors++; $display("FAIL stray_ack_id: got %h want 03", IN_PORT_DATA); end
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL stray_ack_intr: got %b want 0", INTR); end
   endtask

   task automatic test_back_to_back();
      wr(8'hF0, 8'hFF);
      IRQ_IN[0] = 1'b1; tick();
      IRQ_IN[0] = 1'b0; tick(); tick(); tick();
      checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL b2b_intr: got %b want 1", INTR); end
      IRQ_IN[0] = 1'b1; tick(); tick();
      INTR_ACK = 1'b1; tick(); INTR_ACK = 1'b0;
      IRQ_IN = '0;
      PORT_ID = 8'hF1; #1;
      checks++; if (IN_PORT_DATA !== 8'h01) begin errors++; $display("FAIL b2b_setwins: got %h want 01", IN_PORT_DATA); end
      PORT_ID = 8'hF2; #1;
      checks++; if (IN_PORT_DATA !== 8'h80) begin errors++; $display("FAIL b2b_id: got %h want 80", IN_PORT_DATA); end
      for (int k = 0; k < 3; k++) begin
         IRQ_IN[1] = 1'b1; tick();
         IRQ_IN[1] = 1'b0; tick();
      end
      repeat (3) tick();
      PORT_ID = 8'hF1; #1;
      checks++; if (IN_PORT_DATA !== 8'h03) begin errors++; $display("FAIL b2b_coalesce: got %h want 03", IN_PORT_DATA); end
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL b2b_nonest: got %b want 0", INTR); end
   endtask

   task automatic test_reset_mid();
      wr(8'hF1, 8'hFF);
      IRQ_IN = 8'h11; tick();
      IRQ_IN = 8'h00; repeat (3) tick();
      PORT_ID = 8'hF1; #1;
      checks++; if (IN_PORT_DATA !== 8'h11) begin errors++; $display("FAIL rmid_pend0: got %h want 11", IN_PORT_DATA); end
      #2 RESET_N = 1'b0;
      #1;
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL rmid_intr: got %b want 0", INTR); end
      for (int p = 0; p < 3; p++) begin
         PORT_ID = 8'hF0 + 8'(p);
         #1;
         checks++;
         if (IN_PORT_DATA !== 8'h00) begin
            errors++; $display("FAIL rmid_read_%h: got %h want 00", PORT_ID, IN_PORT_DATA);
         end
      end
      @(negedge CLK) RESET_N = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic [7:0] ports [0:3];
      logic [7:0] exp_rd;
      ports = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
      @(negedge CLK) RESET_N = 1'b0;
      IRQ_IN = '0; IO_STRB = 1'b0; INTR_ACK = 1'b0;
      tick();
      @(negedge CLK) RESET_N = 1'b1;
      tick();
      for (int c = 0; c < 3000; c++) begin
         IRQ_IN   = IRQ_IN ^ 8'($urandom & $urandom & $urandom);
         IO_STRB  = ($urandom_range(0, 3) == 0);
         PORT_ID  = ($urandom_range(0, 4) == 4) ? 8'($urandom) : ports[$urandom_range(0, 3)];
         OUT_PORT = (PORT_ID == 8'hF1) ? 8'($urandom & $urandom) : 8'($urandom);
         INTR_ACK = INTR ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         tick();
         exp_rd = model_read(ms, PORT_ID);
         checks++;
         if (INTR !== ms.intr) begin
            errors++; $display("FAIL rnd_intr c=%0d: got %b want %b", c, INTR, ms.intr);
         end
         checks++;
         if (IN_PORT_DATA !== exp_rd) begin
            errors++; $display("FAIL rnd_read c=%0d port=%h: got %h want %h", c, PORT_ID, IN_PORT_DATA, exp_rd);
         end
      end
      IO_STRB = 1'b0; INTR_ACK = 1'b0;
   endtask

   initial begin
      test_reset();
      test_edge_latency();
      test_ack_eoi();
      test_masked();
      test_w1c_cancel();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
